// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, BCD constants and helpers for the game timer
package game_pkg;
  localparam int BCD_W = 4;
  localparam int MAX_DIGITS = 8;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSED = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;
  function automatic logic [BCD_W*MAX_DIGITS-1:0] bcd_all_nines(input int digits);
    logic [BCD_W*MAX_DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) if (i < digits) r[i*BCD_W +: BCD_W] = 4'h9;
    return r;
  endfunction
endpackage

// File: rtl/bcd_incr.sv
// bcd_incr: combinational multi-digit BCD +1; all_nines_o flags the carry out of the top digit
module bcd_incr
  import game_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [BCD_W*DIGITS-1:0] val_i,
  output logic [BCD_W*DIGITS-1:0] sum_o,
  output logic                    all_nines_o
);
  logic             carry;
  logic [BCD_W-1:0] dig;
  // ripple the +1 carry from digit 0 upward; a 9 with carry-in rolls to 0
  always_comb begin
    carry = 1'b1;
    dig = '0;
    sum_o = val_i;
    for (int i = 0; i < DIGITS; i++) begin
      dig = val_i[i*BCD_W +: BCD_W];
      sum_o[i*BCD_W +: BCD_W] = carry ? (dig == 4'h9 ? 4'h0 : dig + 4'h1) : dig;
      carry = carry && dig == 4'h9;
    end
    all_nines_o = carry;
  end
endmodule

// File: rtl/game_timer_best.sv
// game_timer_best: BCD run timer with pause, hole restart/penalty and best-time record
module game_timer_best
  import game_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int TICK_RATE    = 10,
  parameter int DIGITS       = 4,
  parameter int HOLE_PENALTY = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    won_the_game,
  input  logic                    hit_a_hole,
  input  logic                    clear_best,
  output logic [BCD_W*DIGITS-1:0] timer,
  output logic [BCD_W*DIGITS-1:0] best,
  output logic                    best_valid,
  output logic                    new_best,
  output logic                    running,
  output logic                    saturated
);
  localparam int TW = BCD_W*DIGITS;
  localparam int PERIOD = CLK_FREQ/TICK_RATE;
  localparam int PSW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  localparam int PNW = HOLE_PENALTY > 0 ? $clog2(HOLE_PENALTY*4+1) : 1;
  localparam logic [TW-1:0] NINES = TW'(bcd_all_nines(DIGITS));
  localparam logic [PSW-1:0] PS_LAST = PSW'(PERIOD-1);
  localparam logic [PNW-1:0] PN_MAX = '1;
  localparam logic [PNW:0] PN_ADD = (PNW+1)'(HOLE_PENALTY);

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d, best_q, best_d, inc_val;
  logic [PSW-1:0] presc_q, presc_d;
  logic [PNW-1:0] pen_q, pen_d;
  logic [PNW:0]   pen_sum;
  logic           best_valid_q, best_valid_d, new_best_q, new_best_d, saturated_q, saturated_d;
  logic           all9, in_play, win, hole, tick, drain, done_entry, upd;

  bcd_incr #(.DIGITS(DIGITS)) u_incr (
    .val_i       (timer_q),
    .sum_o       (inc_val),
    .all_nines_o (all9)
  );

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      presc_q      <= '0;
      pen_q        <= '0;
      best_q       <= NINES;
      best_valid_q <= 1'b0;
      new_best_q   <= 1'b0;
      saturated_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      presc_q      <= presc_d;
      pen_q        <= pen_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
      new_best_q   <= new_best_d;
      saturated_q  <= saturated_d;
    end
  end

  // next state, timer, prescaler and penalty; a win masks both the tick and the hole
  always_comb begin
    in_play = state_q == ST_RUN || state_q == ST_PAUSED;
    win = in_play && won_the_game;
    hole = in_play && hit_a_hole && !won_the_game;
    tick = state_q == ST_RUN && presc_q == PS_LAST && !won_the_game;
    drain = pen_q != '0 && (state_q == ST_RUN || state_q == ST_SETTLE);
    state_d = state_q;
    presc_d = state_q == ST_RUN && !won_the_game ? (tick ? '0 : presc_q + 1'b1) : presc_q;
    timer_d = (tick || drain) && !all9 ? inc_val : timer_q;
    pen_d = pen_q - PNW'(drain && !tick);
    pen_sum = {1'b0, pen_d} + PN_ADD;
    if (hole && HOLE_PENALTY == 0) begin
      timer_d = '0;
      presc_d = '0;
    end
    if (hole && HOLE_PENALTY != 0) pen_d = pen_sum > {1'b0, PN_MAX} ? PN_MAX : pen_sum[PNW-1:0];
    case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        state_d = ST_RUN;
        timer_d = '0;
        presc_d = '0;
        pen_d = '0;
      end
      ST_RUN, ST_PAUSED: state_d = win ? (pen_q != '0 ? ST_SETTLE : ST_DONE) : pause ? ST_PAUSED : ST_RUN;
      ST_SETTLE: state_d = pen_d == '0 ? ST_DONE : ST_SETTLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // best-time capture on DONE entry; a capture wins over clear_best
  always_comb begin
    done_entry = state_d == ST_DONE && state_q != ST_DONE;
    upd = done_entry && (!best_valid_q || timer_d < best_q);
    best_d = upd ? timer_d : clear_best ? NINES : best_q;
    best_valid_d = upd || (best_valid_q && !clear_best);
    new_best_d = upd;
    saturated_d = timer_d == NINES;
  end

  assign timer = timer_q;
  assign best = best_q;
  assign best_valid = best_valid_q;
  assign new_best = new_best_q;
  assign running = state_q == ST_RUN;
  assign saturated = saturated_q;
endmodule

// File: tb/tb_game_timer_best.sv
// tb_game_timer_best: directed checks of two timer instances (hole restart and hole penalty)
module tb_game_timer_best;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, won = 1'b0, hole = 1'b0, clr = 1'b0;
  logic [7:0] t0, b0, t5, b5;
  logic bv0, nb0, r0, s0, bv5, nb5, r5, s5;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  game_timer_best #(.CLK_FREQ(100), .TICK_RATE(10), .DIGITS(2), .HOLE_PENALTY(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .won_the_game(won), .hit_a_hole(hole),
    .clear_best(clr), .timer(t0), .best(b0), .best_valid(bv0), .new_best(nb0), .running(r0), .saturated(s0));

  game_timer_best #(.CLK_FREQ(100), .TICK_RATE(10), .DIGITS(2), .HOLE_PENALTY(5)) u_dut5 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .won_the_game(won), .hit_a_hole(hole),
    .clear_best(clr), .timer(t5), .best(b5), .best_valid(bv5), .new_best(nb5), .running(r5), .saturated(s5));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (t0 !== 8'h00) begin miscompares++; $display("FAIL reset_timer got %h want 00", t0); end
    vectors++; if (b0 !== 8'h99) begin miscompares++; $display("FAIL reset_best got %h want 99", b0); end
    vectors++; if ({bv0, nb0, r0, s0} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b want 0000", {bv0, nb0, r0, s0}); end
  endtask

  task automatic test_saturate();
    do_reset();
    do_start();
    vectors++; if (r0 !== 1'b1) begin miscompares++; $display("FAIL sat_running got %b want 1", r0); end
    step(500);
    vectors++; if ({t0, s0} !== {8'h50, 1'b0}) begin miscompares++; $display("FAIL sat_mid got %h/%b want 50/0", t0, s0); end
    step(500);
    vectors++; if ({t0, s0} !== {8'h99, 1'b1}) begin miscompares++; $display("FAIL sat_full got %h/%b want 99/1", t0, s0); end
    step(100);
    vectors++; if ({t0, s0} !== {8'h99, 1'b1}) begin miscompares++; $display("FAIL sat_hold got %h/%b want 99/1", t0, s0); end
    do_start();
    vectors++; if ({t0, s0} !== {8'h99, 1'b1}) begin miscompares++; $display("FAIL start_in_run got %h/%b want 99/1", t0, s0); end
  endtask

  task automatic test_best();
    do_reset();
    do_start();
    step(250);
    vectors++; if (t0 !== 8'h25) begin miscompares++; $display("FAIL best_run1 got %h want 25", t0); end
    won = 1'b1;
    step(1);
    won = 1'b0;
    vectors++; if ({t0, b0, bv0, nb0, r0} !== {8'h25, 8'h25, 3'b110}) begin miscompares++; $display("FAIL best_first got t=%h b=%h f=%b want 25 25 110", t0, b0, {bv0, nb0, r0}); end
    step(1);
    vectors++; if ({t0, nb0} !== {8'h25, 1'b0}) begin miscompares++; $display("FAIL best_pulse got %h/%b want 25/0", t0, nb0); end
    step(20);
    vectors++; if (t0 !== 8'h25) begin miscompares++; $display("FAIL done_hold got %h want 25", t0); end
    do_start();
    step(300);
    won = 1'b1;
    step(1);
    won = 1'b0;
    vectors++; if ({t0, b0, bv0, nb0} !== {8'h30, 8'h25, 2'b10}) begin miscompares++; $display("FAIL best_keep got t=%h b=%h f=%b want 30 25 10", t0, b0, {bv0, nb0}); end
  endtask

  task automatic test_hole_restart();
    do_reset();
    do_start();
    step(73);
    vectors++; if (t0 !== 8'h07) begin miscompares++; $display("FAIL hole_pre got %h want 07", t0); end
    hole = 1'b1;
    step(1);
    hole = 1'b0;
    vectors++; if ({t0, r0} !== {8'h00, 1'b1}) begin miscompares++; $display("FAIL hole_clear got %h/%b want 00/1", t0, r0); end
    step(9);
    vectors++; if (t0 !== 8'h00) begin miscompares++; $display("FAIL hole_early got %h want 00", t0); end
    step(1);
    vectors++; if (t0 !== 8'h01) begin miscompares++; $display("FAIL hole_tick got %h want 01", t0); end
  endtask

  task automatic test_hole_penalty();
    do_reset();
    do_start();
    step(120);
    hole = 1'b1;
    step(1);
    hole = 1'b0;
    vectors++; if (t5 !== 8'h12) begin miscompares++; $display("FAIL pen_add got %h want 12", t5); end
    step(1);
    vectors++; if (t5 !== 8'h13) begin miscompares++; $display("FAIL pen_drain got %h want 13", t5); end
    won = 1'b1;
    step(1);
    won = 1'b0;
    vectors++; if ({t5, r5, nb5, bv5} !== {8'h14, 3'b000}) begin miscompares++; $display("FAIL pen_settle got %h/%b want 14/000", t5, {r5, nb5, bv5}); end
    step(2);
    vectors++; if ({t5, nb5} !== {8'h16, 1'b0}) begin miscompares++; $display("FAIL pen_settle2 got %h/%b want 16/0", t5, nb5); end
    step(1);
    vectors++; if ({t5, b5, nb5, bv5} !== {8'h17, 8'h17, 2'b11}) begin miscompares++; $display("FAIL pen_done got t=%h b=%h f=%b want 17 17 11", t5, b5, {nb5, bv5}); end
    step(3);
    vectors++; if ({t5, nb5} !== {8'h17, 1'b0}) begin miscompares++; $display("FAIL pen_hold got %h/%b want 17/0", t5, nb5); end
  endtask

  task automatic test_pause();
    do_reset();
    do_start();
    step(43);
    pause = 1'b1;
    step(1);
    vectors++; if ({t0, r0} !== {8'h04, 1'b0}) begin miscompares++; $display("FAIL pause_enter got %h/%b want 04/0", t0, r0); end
    step(36);
    vectors++; if (t0 !== 8'h04) begin miscompares++; $display("FAIL pause_frozen got %h want 04", t0); end
    pause = 1'b0;
    step(1);
    vectors++; if (r0 !== 1'b1) begin miscompares++; $display("FAIL pause_resume got %b want 1", r0); end
    step(5);
    vectors++; if (t0 !== 8'h04) begin miscompares++; $display("FAIL pause_early got %h want 04", t0); end
    step(1);
    vectors++; if (t0 !== 8'h05) begin miscompares++; $display("FAIL pause_tick got %h want 05", t0); end
  endtask

  task automatic test_win_collision();
    do_reset();
    do_start();
    step(59);
    vectors++; if (t0 !== 8'h05) begin miscompares++; $display("FAIL coll_pre got %h want 05", t0); end
    won = 1'b1;
    hole = 1'b1;
    step(1);
    won = 1'b0;
    hole = 1'b0;
    vectors++; if ({t0, r0, nb0, b0} !== {8'h05, 2'b01, 8'h05}) begin miscompares++; $display("FAIL coll_dut0 got t=%h f=%b b=%h want 05 01 05", t0, {r0, nb0}, b0); end
    vectors++; if ({t5, r5, nb5, b5} !== {8'h05, 2'b01, 8'h05}) begin miscompares++; $display("FAIL coll_dut5 got t=%h f=%b b=%h want 05 01 05", t5, {r5, nb5}, b5); end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    vectors++; if ({b0, bv0, t0} !== {8'h99, 1'b0, 8'h05}) begin miscompares++; $display("FAIL clear_best got b=%h v=%b t=%h want 99 0 05", b0, bv0, t0); end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_best();
    test_hole_restart();
    test_hole_penalty();
    test_pause();
    test_win_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/game_timer_best.md
Name: game_timer_best

Overview:
Parametrised run timer for the maze game. A start/pause/finish state machine counts elapsed game time in BCD at a configurable tick rate. It applies either a restart or a time penalty when the ball hits a hole, and keeps a best-time register with a new-record pulse. It sits between the game-state logic and the seven-segment display driver.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
TICK_RATE, 10, timer increments per second
DIGITS, 4, number of BCD digits in timer and best (range 1-8)
HOLE_PENALTY, 0, 0 means a hole clears the timer; N>0 means a hole adds N ticks

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  level/pulse; begins a new run
pause  in  1  level; freezes the timer while high
won_the_game  in  1  finish event
hit_a_hole  in  1  hole event
clear_best  in  1  invalidates the best register
timer  out  4*DIGITS  current time in BCD, digit 0 at LSBs
best  out  4*DIGITS  best time in BCD
best_valid  out  1  best holds a recorded time
new_best  out  1  one-cycle pulse when best is updated
running  out  1  high in RUN
saturated  out  1  timer stuck at all-9s

Behaviour:
- Reset values: state IDLE, timer 0, prescaler 0, penalty counter 0, best all-9s, best_valid 0, new_best 0, saturated 0.
- States: IDLE, RUN, PAUSED, SETTLE, DONE.
- IDLE/DONE + start: next cycle enters RUN with timer=0, prescaler=0, penalty counter=0, saturated=0. start in RUN/PAUSED/SETTLE is ignored.
- Prescaler:
  - Counts only in RUN. tick is asserted when prescaler==CLK_FREQ/TICK_RATE-1, then prescaler wraps to 0.
  - First increment lands CLK_FREQ/TICK_RATE cycles after RUN entry.
  - The prescaler holds its value in PAUSED.
- Timer increment:
  - BCD +1 with per-digit carry.
  - At all-9s the timer holds and saturated=1.
- pause high in RUN → PAUSED. pause low in PAUSED → RUN.
- Hole in RUN or PAUSED:
  - HOLE_PENALTY==0: timer and prescaler cleared next cycle; state unchanged.
  - Otherwise: penalty counter += HOLE_PENALTY, saturating at its width of clog2(HOLE_PENALTY*4+1).
- Penalty drain:
  - While the penalty counter is >0 and the state is RUN or SETTLE, the timer is incremented once per clock and the counter decrements.
  - A tick coinciding with a drain cycle does not decrement the counter that cycle, so no tick is lost.
  - PAUSED freezes the drain.
- won_the_game in RUN or PAUSED:
  - The tick in that same cycle is not counted.
  - Go to SETTLE if the penalty counter is >0, otherwise go to DONE.
  - SETTLE goes to DONE on the cycle the counter reaches 0.
- Best update:
  - Evaluated on the DONE entry edge, comparing BCD digits MSB first.
  - If !best_valid or timer<best: best←timer, best_valid←1, and new_best=1 for exactly one cycle, aligned with the first DONE cycle.
  - A tie does not update.
- Priorities in one cycle: reset > won_the_game > hit_a_hole > tick. A hole in the same cycle as a win is ignored.
- won_the_game and hit_a_hole are ignored in IDLE, SETTLE and DONE.
- clear_best: best←all-9s, best_valid←0 next cycle, in any state. It is overridden if a best update occurs in the same cycle.
- In DONE the timer holds its final value until start.
- Reset mid-run returns to IDLE and clears everything, including best.

Decomposition:
- Shared package game_pkg:
  - State enum encoding (3 bits).
  - BCD digit width constant 4.
  - Function bcd_all_nines(DIGITS).
- One sub-module: bcd_incr, a combinational DIGITS-wide BCD +1 with carry-out/saturate flag. It is reused by tick and drain paths. The top level owns the FSM, prescaler, penalty counter and best compare.

Test Plan:
1. CLK_FREQ=100, TICK_RATE=10, DIGITS=2: start, wait 1000 cycles → timer 8'h99 with saturated=1; 10 more ticks → still 8'h99.
2. Run 25 ticks, pulse won_the_game → DONE with timer 8'h25, best 8'h25, best_valid=1, new_best high for 1 cycle; next run finishing at 8'h30 → best stays 8'h25, no pulse.
3. HOLE_PENALTY=0: hole at timer 8'h07 → next cycle timer 8'h00, prescaler 0, state RUN; next increment after 10 cycles.
4. HOLE_PENALTY=5: hole at 8'h12, then win 2 cycles later → SETTLE drains to 8'h17 → DONE; new_best asserts only after DONE entry.
5. pause for 37 cycles mid-run → timer and prescaler frozen; resume → next tick at the remaining prescaler distance.
6. won_the_game and hit_a_hole together with tick → timer unchanged, DONE; clear_best in DONE → best 8'h99, best_valid 0.
